// File: rtl/reg_cmd_ctrl_if.sv
// Signal bundle between the serial command controller and its UART / register-file
// neighbours. The controller uses the master view; the environment uses the slave view.
interface reg_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        write_enable;
  logic [7:0]  w_addr;
  logic [15:0] w_data;
  logic [7:0]  r_addr;
  logic [15:0] r_data_o;
  logic        busy;
  logic        drop;

  modport master (
    input  rx_data, rx_valid, tx_ready, r_data_o,
    output tx_data, tx_valid, write_enable, w_addr, w_data, r_addr, busy, drop
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, r_data_o,
    input  tx_data, tx_valid, write_enable, w_addr, w_data, r_addr, busy, drop
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command controller: parses write/read frames from a UART receiver,
// drives the PID register file ports and answers with ACK/NAK or the read data.
module reg_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned RO_BASE        = 13
) (
  input  logic           clk_in,
  input  logic           reset,
  reg_cmd_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]       CMD_WRITE  = 8'h57;
  localparam logic [7:0]       CMD_READ   = 8'h52;
  localparam logic [7:0]       RSP_ACK    = 8'h06;
  localparam logic [7:0]       RSP_NAK    = 8'h15;
  localparam logic [7:0]       NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [7:0]       RO_BASE_B  = 8'(RO_BASE);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_DHI      = 4'd2,
    S_DLO      = 4'd3,
    S_WRITE    = 4'd4,
    S_RD_ISSUE = 4'd5,
    S_RD_WAIT  = 4'd6,
    S_TX_HI    = 4'd7,
    S_TX_LO    = 4'd8,
    S_TX_RESP  = 4'd9
  } state_e;

  function automatic logic is_busy(input state_e s);
    case (s)
      S_IDLE, S_ADDR, S_DHI, S_DLO: is_busy = 1'b0;
      default:                      is_busy = 1'b1;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_hi_q, data_hi_d;
  logic [15:0]      rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             we_q, we_d;
  logic [7:0]       w_addr_q, w_addr_d;
  logic [15:0]      w_data_q, w_data_d;
  logic [7:0]       r_addr_q, r_addr_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             tx_fire_s;

  assign tx_fire_s = tx_valid_q & bus.tx_ready;

  // Frame parser, timeout and response sequencing; all outputs are computed for the next cycle.
  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    data_hi_d  = data_hi_q;
    rd_buf_d   = rd_buf_q;
    cnt_d      = CNT_ZERO;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    we_d       = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    r_addr_d   = r_addr_q;
    drop_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == CMD_WRITE)) begin
          op_wr_d = 1'b1;
          state_d = S_ADDR;
        end else if (bus.rx_valid && (bus.rx_data == CMD_READ)) begin
          op_wr_d = 1'b0;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR, S_DHI, S_DLO: begin
        // An incoming byte beats an expiring timeout on the same cycle.
        if (bus.rx_valid) begin
          cnt_d = CNT_ZERO;
          case (state_q)
            S_ADDR: begin
              addr_d = bus.rx_data;
              if (op_wr_q) begin
                state_d = S_DHI;
              end else if (bus.rx_data < NUM_REGS_B) begin
                r_addr_d = bus.rx_data;
                state_d  = S_RD_ISSUE;
              end else begin
                tx_data_d  = RSP_NAK;
                tx_valid_d = 1'b1;
                state_d    = S_TX_RESP;
              end
            end
            S_DHI: begin
              data_hi_d = bus.rx_data;
              state_d   = S_DLO;
            end
            default: begin
              if (addr_q < RO_BASE_B) begin
                we_d     = 1'b1;
                w_addr_d = addr_q;
                w_data_d = {data_hi_q, bus.rx_data};
                state_d  = S_WRITE;
              end else begin
                tx_data_d  = RSP_NAK;
                tx_valid_d = 1'b1;
                state_d    = S_TX_RESP;
              end
            end
          endcase
        end else if (cnt_q >= TIMEOUT_C) begin
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WRITE: begin
        drop_d     = bus.rx_valid;
        tx_data_d  = RSP_ACK;
        tx_valid_d = 1'b1;
        state_d    = S_TX_RESP;
      end

      S_RD_ISSUE: begin
        drop_d  = bus.rx_valid;
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        drop_d     = bus.rx_valid;
        rd_buf_d   = bus.r_data_o;
        tx_data_d  = bus.r_data_o[15:8];
        tx_valid_d = 1'b1;
        state_d    = S_TX_HI;
      end

      S_TX_HI: begin
        drop_d = bus.rx_valid;
        if (tx_fire_s) begin
          tx_data_d = rd_buf_q[7:0];
          state_d   = S_TX_LO;
        end else begin
          tx_data_d = rd_buf_q[15:8];
          state_d   = S_TX_HI;
        end
      end

      S_TX_LO, S_TX_RESP: begin
        drop_d = bus.rx_valid;
        if (tx_fire_s) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    busy_d = is_busy(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_wr_q    <= 1'b0;
      addr_q     <= 8'h00;
      data_hi_q  <= 8'h00;
      rd_buf_q   <= 16'h0000;
      cnt_q      <= CNT_ZERO;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      w_addr_q   <= 8'h00;
      w_data_q   <= 16'h0000;
      r_addr_q   <= 8'h00;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      data_hi_q  <= data_hi_d;
      rd_buf_q   <= rd_buf_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      r_addr_q   <= r_addr_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.write_enable = we_q;
  assign bus.w_addr       = w_addr_q;
  assign bus.w_data       = w_data_q;
  assign bus.r_addr       = r_addr_q;
  assign bus.busy         = busy_q;
  assign bus.drop         = drop_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl with a small register-file model and a
// negedge monitor counting writes, drops and tx transfers.
module tb_reg_cmd_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   we_cnt   = 0;
  int   drop_cnt = 0;
  int   tx_cnt   = 0;
  logic [15:0] mem [16];

  always #5 clk = ~clk;

  reg_cmd_ctrl_if bus_if ();

  reg_cmd_ctrl #(
    .TIMEOUT_CYCLES(8),
    .NUM_REGS      (16),
    .RO_BASE       (13)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Register file: one write port, registered read, fixed preload on reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) mem[k] <= 16'h0000;
      mem[1]  <= 16'h1357;
      mem[3]  <= 16'hBEEF;
      mem[15] <= 16'hC0DE;
      bus_if.r_data_o <= 16'h0000;
    end else begin
      if (bus_if.write_enable) mem[bus_if.w_addr[3:0]] <= bus_if.w_data;
      bus_if.r_data_o <= mem[bus_if.r_addr[3:0]];
    end
  end

  always @(negedge clk) begin
    if (bus_if.write_enable) we_cnt <= we_cnt + 1;
    if (bus_if.drop) drop_cnt <= drop_cnt + 1;
    if (bus_if.tx_valid && bus_if.tx_ready) tx_cnt <= tx_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    step(1);
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL rst_tx_valid got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.tx_data !== 8'h00) $display("FAIL rst_tx_data got=%0h exp=0", bus_if.tx_data); else n_pass++;
    n_checks++; if (bus_if.write_enable !== 1'b0) $display("FAIL rst_we got=%0h exp=0", bus_if.write_enable); else n_pass++;
    n_checks++; if (bus_if.w_addr !== 8'h00) $display("FAIL rst_w_addr got=%0h exp=0", bus_if.w_addr); else n_pass++;
    n_checks++; if (bus_if.w_data !== 16'h0000) $display("FAIL rst_w_data got=%0h exp=0", bus_if.w_data); else n_pass++;
    n_checks++; if (bus_if.r_addr !== 8'h00) $display("FAIL rst_r_addr got=%0h exp=0", bus_if.r_addr); else n_pass++;
    n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL rst_busy got=%0h exp=0", bus_if.busy); else n_pass++;
    n_checks++; if (bus_if.drop !== 1'b0) $display("FAIL rst_drop got=%0h exp=0", bus_if.drop); else n_pass++;
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_ignore;
    int d0 = drop_cnt;
    send_byte(8'h00);
    n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL ign_busy got=%0h exp=0", bus_if.busy); else n_pass++;
    send_byte(8'hFF);
    send_byte(8'h06);
    step(1);
    n_checks++; if (drop_cnt - d0 !== 0) $display("FAIL ign_drop got=%0d exp=0", drop_cnt - d0); else n_pass++;
  endtask

  task automatic test_write;
    int w0 = we_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    n_checks++; if (bus_if.write_enable !== 1'b1) $display("FAIL wr_we got=%0h exp=1", bus_if.write_enable); else n_pass++;
    n_checks++; if (bus_if.w_addr !== 8'h00) $display("FAIL wr_addr got=%0h exp=0", bus_if.w_addr); else n_pass++;
    n_checks++; if (bus_if.w_data !== 16'h1234) $display("FAIL wr_data got=%0h exp=1234", bus_if.w_data); else n_pass++;
    n_checks++; if (bus_if.busy !== 1'b1) $display("FAIL wr_busy got=%0h exp=1", bus_if.busy); else n_pass++;
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL wr_early_tx got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL wr_ack_valid got=%0h exp=1", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.tx_data !== 8'h06) $display("FAIL wr_ack_data got=%0h exp=06", bus_if.tx_data); else n_pass++;
    n_checks++; if (bus_if.write_enable !== 1'b0) $display("FAIL wr_we_once got=%0h exp=0", bus_if.write_enable); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL wr_tx_end got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL wr_busy_end got=%0h exp=0", bus_if.busy); else n_pass++;
    n_checks++; if (bus_if.w_data !== 16'h1234) $display("FAIL wr_data_hold got=%0h exp=1234", bus_if.w_data); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 1) $display("FAIL wr_we_count got=%0d exp=1", we_cnt - w0); else n_pass++;
  endtask

  task automatic test_read;
    send_byte(8'h52); send_byte(8'h03);
    n_checks++; if (bus_if.r_addr !== 8'h03) $display("FAIL rd_r_addr got=%0h exp=03", bus_if.r_addr); else n_pass++;
    n_checks++; if (bus_if.busy !== 1'b1) $display("FAIL rd_busy got=%0h exp=1", bus_if.busy); else n_pass++;
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL rd_tx_n1 got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL rd_tx_n2 got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL rd_hi_valid got=%0h exp=1", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.tx_data !== 8'hBE) $display("FAIL rd_hi_data got=%0h exp=BE", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL rd_lo_valid got=%0h exp=1", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.tx_data !== 8'hEF) $display("FAIL rd_lo_data got=%0h exp=EF", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL rd_tx_end got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL rd_busy_end got=%0h exp=0", bus_if.busy); else n_pass++;
  endtask

  task automatic test_errors;
    int w0 = we_cnt;
    send_byte(8'h57); send_byte(8'h0E); send_byte(8'hAA); send_byte(8'h55);
    n_checks++; if (bus_if.write_enable !== 1'b0) $display("FAIL ro_we got=%0h exp=0", bus_if.write_enable); else n_pass++;
    n_checks++; if (bus_if.tx_data !== 8'h15) $display("FAIL ro_nak got=%0h exp=15", bus_if.tx_data); else n_pass++;
    n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL ro_nak_valid got=%0h exp=1", bus_if.tx_valid); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL ro_nak_end got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    send_byte(8'h57); send_byte(8'h0D); send_byte(8'h12); send_byte(8'h34);
    n_checks++; if (bus_if.tx_data !== 8'h15) $display("FAIL ro_base_nak got=%0h exp=15", bus_if.tx_data); else n_pass++;
    step(1);
    send_byte(8'h57); send_byte(8'h0C); send_byte(8'h5A); send_byte(8'hA5);
    n_checks++; if (bus_if.write_enable !== 1'b1) $display("FAIL rw_top_we got=%0h exp=1", bus_if.write_enable); else n_pass++;
    n_checks++; if (bus_if.w_addr !== 8'h0C) $display("FAIL rw_top_addr got=%0h exp=0C", bus_if.w_addr); else n_pass++;
    n_checks++; if (bus_if.w_data !== 16'h5AA5) $display("FAIL rw_top_data got=%0h exp=5AA5", bus_if.w_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'h06) $display("FAIL rw_top_ack got=%0h exp=06", bus_if.tx_data); else n_pass++;
    step(1);
    send_byte(8'h52); send_byte(8'h20);
    n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL rd_oor_valid got=%0h exp=1", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.tx_data !== 8'h15) $display("FAIL rd_oor_nak got=%0h exp=15", bus_if.tx_data); else n_pass++;
    n_checks++; if (bus_if.r_addr !== 8'h03) $display("FAIL rd_oor_r_addr got=%0h exp=03", bus_if.r_addr); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL rd_oor_end got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    send_byte(8'h52); send_byte(8'h10);
    n_checks++; if (bus_if.tx_data !== 8'h15) $display("FAIL rd_16_nak got=%0h exp=15", bus_if.tx_data); else n_pass++;
    step(1);
    send_byte(8'h52); send_byte(8'h0F);
    n_checks++; if (bus_if.r_addr !== 8'h0F) $display("FAIL rd_15_r_addr got=%0h exp=0F", bus_if.r_addr); else n_pass++;
    step(2);
    n_checks++; if (bus_if.tx_data !== 8'hC0) $display("FAIL rd_15_hi got=%0h exp=C0", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'hDE) $display("FAIL rd_15_lo got=%0h exp=DE", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (we_cnt - w0 !== 1) $display("FAIL err_we_count got=%0d exp=1", we_cnt - w0); else n_pass++;
  endtask

  task automatic test_timeout;
    int w0 = we_cnt;
    int t0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h01);
    step(9);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL to_no_tx got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    send_byte(8'h52); send_byte(8'h01);
    step(2);
    n_checks++; if (bus_if.tx_data !== 8'h13) $display("FAIL to_rd_hi got=%0h exp=13", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'h57) $display("FAIL to_rd_lo got=%0h exp=57", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (we_cnt - w0 !== 0) $display("FAIL to_no_write got=%0d exp=0", we_cnt - w0); else n_pass++;
    n_checks++; if (tx_cnt - t0 !== 2) $display("FAIL to_tx_count got=%0d exp=2", tx_cnt - t0); else n_pass++;
    send_byte(8'h57); send_byte(8'h05);
    step(8);
    send_byte(8'hA1);
    step(8);
    send_byte(8'hB2);
    n_checks++; if (bus_if.write_enable !== 1'b1) $display("FAIL exp_we got=%0h exp=1", bus_if.write_enable); else n_pass++;
    n_checks++; if (bus_if.w_addr !== 8'h05) $display("FAIL exp_addr got=%0h exp=05", bus_if.w_addr); else n_pass++;
    n_checks++; if (bus_if.w_data !== 16'hA1B2) $display("FAIL exp_data got=%0h exp=A1B2", bus_if.w_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'h06) $display("FAIL exp_ack got=%0h exp=06", bus_if.tx_data); else n_pass++;
    step(1);
  endtask

  task automatic test_stall;
    int d0 = drop_cnt;
    bus_if.tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h03);
    step(2);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        send_byte(8'h57);
        n_checks++; if (bus_if.drop !== 1'b1) $display("FAIL st_drop got=%0h exp=1", bus_if.drop); else n_pass++;
      end else begin
        step(1);
      end
      n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL st_valid[%0d] got=%0h exp=1", i, bus_if.tx_valid); else n_pass++;
      n_checks++; if (bus_if.tx_data !== 8'hBE) $display("FAIL st_data[%0d] got=%0h exp=BE", i, bus_if.tx_data); else n_pass++;
    end
    n_checks++; if (drop_cnt - d0 !== 1) $display("FAIL st_drop_count got=%0d exp=1", drop_cnt - d0); else n_pass++;
    bus_if.tx_ready = 1'b1;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'hEF) $display("FAIL st_lo got=%0h exp=EF", bus_if.tx_data); else n_pass++;
    n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL st_lo_valid got=%0h exp=1", bus_if.tx_valid); else n_pass++;
    step(1);
    n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL st_busy_end got=%0h exp=0", bus_if.busy); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int w0 = we_cnt;
    send_byte(8'h57); send_byte(8'h02);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_checks++; if (bus_if.w_addr !== 8'h00) $display("FAIL rm_w_addr got=%0h exp=0", bus_if.w_addr); else n_pass++;
    n_checks++; if (bus_if.w_data !== 16'h0000) $display("FAIL rm_w_data got=%0h exp=0", bus_if.w_data); else n_pass++;
    n_checks++; if (bus_if.r_addr !== 8'h00) $display("FAIL rm_r_addr got=%0h exp=0", bus_if.r_addr); else n_pass++;
    send_byte(8'h88); send_byte(8'h99);
    step(3);
    n_checks++; if (we_cnt - w0 !== 0) $display("FAIL rm_no_write got=%0d exp=0", we_cnt - w0); else n_pass++;
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL rm_no_tx got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    bus_if.tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h03);
    step(2);
    n_checks++; if (bus_if.tx_valid !== 1'b1) $display("FAIL rm_tx_pre got=%0h exp=1", bus_if.tx_valid); else n_pass++;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus_if.tx_ready = 1'b1;
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL rm_tx_drop got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL rm_busy got=%0h exp=0", bus_if.busy); else n_pass++;
    send_byte(8'h57); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    n_checks++; if (bus_if.write_enable !== 1'b1) $display("FAIL rm_wr_we got=%0h exp=1", bus_if.write_enable); else n_pass++;
    n_checks++; if (bus_if.w_data !== 16'h1122) $display("FAIL rm_wr_data got=%0h exp=1122", bus_if.w_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'h06) $display("FAIL rm_wr_ack got=%0h exp=06", bus_if.tx_data); else n_pass++;
    step(1);
  endtask

  task automatic test_back_to_back;
    send_byte(8'h57); send_byte(8'h07); send_byte(8'h9C); send_byte(8'h3D);
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'h06) $display("FAIL b2b_ack got=%0h exp=06", bus_if.tx_data); else n_pass++;
    step(1);
    send_byte(8'h52); send_byte(8'h07);
    step(2);
    n_checks++; if (bus_if.tx_data !== 8'h9C) $display("FAIL b2b_hi got=%0h exp=9C", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'h3D) $display("FAIL b2b_lo got=%0h exp=3D", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_valid !== 1'b0) $display("FAIL b2b_idle got=%0h exp=0", bus_if.tx_valid); else n_pass++;
    send_byte(8'h52); send_byte(8'h03);
    step(2);
    n_checks++; if (bus_if.tx_data !== 8'hBE) $display("FAIL b2b2_hi got=%0h exp=BE", bus_if.tx_data); else n_pass++;
    step(1);
    n_checks++; if (bus_if.tx_data !== 8'hEF) $display("FAIL b2b2_lo got=%0h exp=EF", bus_if.tx_data); else n_pass++;
    step(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_ignore();
    test_write();
    test_read();
    test_errors();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
